// File: rtl/aes_round_sequencer.sv
// AES-128 encrypt round sequencer: initial AddRoundKey, then NR issues to a shared
// SubByte/MixColumn datapath, XORing each returned state with its round key.
module aes_round_sequencer #(
  parameter int DATA_WIDTH = 128,
  parameter int NR         = 10,
  parameter int RK_IDX_W   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [RK_IDX_W-1:0]   rk_idx,
  input  logic [DATA_WIDTH-1:0] rk_in,
  output logic                  dp_valid_out,
  output logic [DATA_WIDTH-1:0] dp_state_out,
  output logic                  dp_final,
  input  logic                  dp_valid_in,
  input  logic [DATA_WIDTH-1:0] dp_state_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NR);
  localparam logic [TW-1:0]       TMAX     = TW'(TIMEOUT - 1);

  logic [2:0]            fsm;
  logic [RK_IDX_W-1:0]   round;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] st;
  // Low while rst is held so in_ready reads 0 even though fsm already sits in IDLE.
  logic                  armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= S_IDLE;
      round <= '0;
      timer <= '0;
      st    <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (fsm)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            st    <= data_in ^ rk_in;
            round <= RK_IDX_W'(1);
            fsm   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          fsm   <= S_WAIT;
        end
        S_WAIT: begin
          // A response landing on the last timeout cycle still wins.
          if (dp_valid_in) begin
            st <= dp_state_in ^ rk_in;
            if (round == LAST_RND) begin
              fsm <= S_DONE;
            end else begin
              round <= round + RK_IDX_W'(1);
              fsm   <= S_ISSUE;
            end
          end else if (timer == TMAX) begin
            fsm <= S_ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) fsm <= S_IDLE;
        end
        S_ERR: fsm <= S_ERR;
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = armed && (fsm == S_IDLE);
  assign rk_idx       = (fsm == S_WAIT) ? round : '0;
  assign dp_valid_out = (fsm == S_ISSUE);
  assign dp_final     = (fsm == S_ISSUE) && (round == LAST_RND);
  assign dp_state_out = st;
  assign out_valid    = (fsm == S_DONE);
  assign data_out     = st;
  assign busy         = (fsm != S_IDLE);
  assign err          = (fsm == S_ERR);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: reference AES datapath (L=2), key store,
// and a ciphertext scoreboard.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         dp_valid_out;
  logic [127:0] dp_state_out;
  logic         dp_final;
  logic         dp_valid_in;
  logic [127:0] dp_state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;
  logic         err;

  aes_round_sequencer #(.DATA_WIDTH(128), .NR(10), .RK_IDX_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .rk_idx(rk_idx), .rk_in(rk_in), .dp_valid_out(dp_valid_out), .dp_state_out(dp_state_out),
    .dp_final(dp_final), .dp_valid_in(dp_valid_in), .dp_state_in(dp_state_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_issue = 0;
  int n_final = 0;
  int final_at = 0;
  logic [127:0] exp_q[$];
  logic [127:0] rk [0:15];

  // ---------------- reference AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] p = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, p);
      p = gmul(p, p);
    end
    if (x == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) t[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) u[w + 4*c] = t[w + 4*((c + w) % 4)];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int w = 0; w < 4; w++) r[127-8*(4*c+w) -: 8] = u[4*c+w];
      end else begin
        r[127-8*(4*c+0) -: 8] = xt(u[4*c]) ^ xt(u[4*c+1]) ^ u[4*c+1] ^ u[4*c+2] ^ u[4*c+3];
        r[127-8*(4*c+1) -: 8] = u[4*c] ^ xt(u[4*c+1]) ^ xt(u[4*c+2]) ^ u[4*c+2] ^ u[4*c+3];
        r[127-8*(4*c+2) -: 8] = u[4*c] ^ u[4*c+1] ^ xt(u[4*c+2]) ^ xt(u[4*c+3]) ^ u[4*c+3];
        r[127-8*(4*c+3) -: 8] = xt(u[4*c]) ^ u[4*c] ^ u[4*c+1] ^ u[4*c+2] ^ xt(u[4*c+3]);
      end
    end
    return r;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  assign rk_in = rk[rk_idx];

  // ---------------- behavioural datapath, L=2 ----------------
  logic         p1v = 1'b0, p2v = 1'b0;
  logic [127:0] p1d, p2d;
  logic         dp_en;
  logic         spur_v;
  logic [127:0] spur_d;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1v <= dp_valid_out;
    p1d <= aes_round(dp_state_out, dp_final);
    p2v <= p1v;
    p2d <= p1d;
    if (dp_valid_out) begin
      n_issue <= n_issue + 1;
      if (dp_final) begin
        n_final  <= n_final + 1;
        final_at <= n_issue + 1;
      end
    end
  end

  assign dp_valid_in = (dp_en & p2v) | spur_v;
  assign dp_state_in = spur_v ? spur_d : p2d;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    if (!out_valid) chk({tag, "_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic pop_cmp(input string tag);
    logic [127:0] e;
    if (exp_q.size() == 0) chk({tag, "_empty"}, 128'd0, 128'd1);
    else begin
      e = exp_q.pop_front();
      chk(tag, data_out, e);
    end
  endtask

  // Waits for in_ready, holds in_valid over the accept edge; returns that edge number.
  task automatic send(input logic [127:0] pt, input logic [127:0] ct, output int t0);
    int n = 0;
    data_in  = pt;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) chk("send_timeout", 128'd0, 128'd1);
    tick();
    t0 = cyc;
    in_valid = 1'b0;
    exp_q.push_back(ct);
  endtask

  initial begin
    int t0, b, a, base, basef, cnt, n;
    logic [127:0] held;

    rst = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    dp_en = 1'b1; spur_v = 1'b0; spur_d = '0;
    load_key(KEY_C1);
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_dp_valid_out", dp_valid_out, 0);
    chk("rst_rk_idx", rk_idx, 0);
    chk("rst_data_out", data_out, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // 1: FIPS-197 C.1 with latency check
    out_ready = 1'b1;
    base = n_issue; basef = n_final;
    send(PT_C1, CT_C1, t0);
    wait_out("c1");
    b = cyc;
    chk("c1_latency", b + 1 - t0, 31);
    pop_cmp("c1_ct");
    tick();
    chk("c1_issues", n_issue - base, 10);
    chk("c1_finals", n_final - basef, 1);
    chk("c1_final_on_10th", final_at - base, 10);
    chk("c1_idle_ready", in_ready, 1);

    // 2: backpressure
    out_ready = 1'b0;
    send(PT_C1, CT_C1, t0);
    wait_out("bp");
    held = data_out;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_data_stable", data_out, held);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    pop_cmp("bp_ct");
    tick();
    chk("bp_release_in_ready", in_ready, 1);

    // 6a: spurious response in IDLE
    held = data_out; base = n_issue;
    spur_v = 1'b1; spur_d = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    tick();
    spur_v = 1'b0;
    tick();
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_ready", in_ready, 1);
    chk("spur_idle_data", data_out, held);
    chk("spur_idle_issues", n_issue - base, 0);

    // 3: back-to-back with in_valid held; second block under the all-zero key
    send(PT_C1, CT_C1, t0);
    data_in = '0; in_valid = 1'b1;
    cnt = 0; n = 0;
    while (!out_valid && n < 200) begin
      tick(); n++;
      if (in_ready) cnt++;
    end
    chk("b2b_no_early_ready", cnt, 0);
    pop_cmp("b2b_ct1");
    tick();
    load_key(128'h0);
    chk("b2b_ready_after_hs", in_ready, 1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(CT_Z);
    chk("b2b_second_accepted", busy, 1);
    wait_out("b2b2");
    pop_cmp("b2b_ct2");
    tick();
    load_key(KEY_C1);

    // 6b: spurious response in DONE
    out_ready = 1'b0;
    send(PT_C1, CT_C1, t0);
    wait_out("spd");
    held = data_out; base = n_issue;
    spur_v = 1'b1; spur_d = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    tick();
    spur_v = 1'b0;
    repeat (3) tick();
    chk("spur_done_valid", out_valid, 1);
    chk("spur_done_data", data_out, held);
    chk("spur_done_issues", n_issue - base, 0);
    out_ready = 1'b1;
    pop_cmp("spur_done_ct");
    tick();

    // 5: reset during round 5 WAIT, then late response
    send(PT_C1, CT_C1, t0);
    n = 0;
    while (rk_idx != 4'd5 && n < 100) begin tick(); n++; end
    if (rk_idx != 4'd5) chk("mid_reach_r5", 128'd0, 128'd1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_in_ready", in_ready, 0);
    chk("mid_busy", busy, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_err", err, 0);
    chk("mid_dp_valid_out", dp_valid_out, 0);
    chk("mid_dp_final", dp_final, 0);
    chk("mid_rk_idx", rk_idx, 0);
    chk("mid_data_out", data_out, 0);
    chk("mid_late_resp_pending", p2v, 1);
    rst = 1'b0;
    tick();
    chk("mid_late_busy", busy, 0);
    chk("mid_late_data", data_out, 0);
    chk("mid_late_ready", in_ready, 1);
    send(PT_C1, CT_C1, t0);
    wait_out("mid_next");
    pop_cmp("mid_next_ct");
    tick();

    // 4: timeout with a silent datapath
    dp_en = 1'b0;
    send(PT_C1, CT_C1, t0);
    n = 0;
    while (!dp_valid_out && n < 10) begin tick(); n++; end
    a = cyc;  // ISSUE visible after edge a, so its cycle ends at edge a+1
    n = 0;
    while (!err && n < 40) begin tick(); n++; end
    b = cyc;
    chk("to_err", err, 1);
    chk("to_err_edge", b - (a + 1), 16);
    chk("to_busy", busy, 1);
    chk("to_in_ready", in_ready, 0);
    chk("to_out_valid", out_valid, 0);
    repeat (5) tick();
    chk("to_sticky", err, 1);
    chk("to_no_reissue", dp_valid_out, 0);
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    dp_en = 1'b1;
    chk("to_rst_err", err, 0);
    chk("to_rst_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
